// File: rtl/seq_pkg.sv
// Shared definitions for the 8-step sequence counter and its receive-side tracker.
// Holds the cycle constant, tracker state encoding and small mask helpers.
package seq_pkg;

   localparam int unsigned SEQ_LEN = 8;

   // Entry i lives in bits [3*i +: 3]; cycle is 2,3,5,2,0,3,4,6.
   localparam logic [3*SEQ_LEN-1:0] SEQ = {3'd6, 3'd4, 3'd3, 3'd0, 3'd2, 3'd5, 3'd3, 3'd2};

   typedef enum logic {
      StHunt   = 1'b0,
      StLocked = 1'b1
   } state_e;

   function automatic logic [2:0] seq_at(input logic [2:0] idx);
      logic [3*SEQ_LEN-1:0] shifted;
      shifted = SEQ >> ({2'b00, idx} * 5'd3);
      return shifted[2:0];
   endfunction

   function automatic logic is_one_hot(input logic [SEQ_LEN-1:0] mask);
      return (mask != '0) && ((mask & (mask - 8'd1)) == '0);
   endfunction

   function automatic logic [2:0] one_hot_index(input logic [SEQ_LEN-1:0] mask);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (mask[i]) idx = i[2:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/seq_tracker_if.sv
// Sample stream in, lock/error status out, for the sequence tracker.
interface seq_tracker_if #(
   parameter int unsigned CNT_W = 16
);
   logic             in_valid;
   logic [2:0]       in_data;
   logic             clr_err;
   logic             locked;
   logic [2:0]       index;
   logic [2:0]       expected;
   logic             mismatch;
   logic [CNT_W-1:0] err_count;

   modport master (
      output in_valid, in_data, clr_err,
      input  locked, index, expected, mismatch, err_count
   );

   modport slave (
      input  in_valid, in_data, clr_err,
      output locked, index, expected, mismatch, err_count
   );
endinterface

// File: rtl/seq_match_rom.sv
// Value to position mask: bit i is set when SEQ[i] equals the value.
module seq_match_rom
   import seq_pkg::*;
(
   input  logic [2:0]         value_i,
   output logic [SEQ_LEN-1:0] mask_o
);

   always_comb begin
      mask_o = '0;
      for (int i = 0; i < SEQ_LEN; i++) begin
         mask_o[i] = (seq_at(i[2:0]) == value_i);
      end
   end

endmodule

// File: rtl/seq_tracker.sv
// Locks onto the position of a 2,3,5,2,0,3,4,6 counter stream, then flywheels the
// index and reports mismatches with a saturating error count.
module seq_tracker
   import seq_pkg::*;
#(
   parameter int unsigned ERR_LIMIT = 2,
   parameter int unsigned CNT_W     = 16
) (
   input logic          clk,
   input logic          rst,
   seq_tracker_if.slave bus
);

   state_e               state_q, state_d;
   logic [SEQ_LEN-1:0]   cand_q, cand_d;
   logic [2:0]           index_q, index_d;
   logic [2:0]           miss_q, miss_d;
   logic                 mismatch_q, mismatch_d;
   logic [CNT_W-1:0]     err_q, err_d;

   logic [SEQ_LEN-1:0]   match_mask;
   logic [SEQ_LEN-1:0]   restart_mask;
   logic [SEQ_LEN-1:0]   hunt_next;
   logic [2:0]           exp_val;

   seq_match_rom u_match_rom (
      .value_i (bus.in_data),
      .mask_o  (match_mask)
   );

   assign restart_mask = (match_mask == '0) ? '1 : match_mask;
   assign exp_val      = seq_at(index_q + 3'd1);

   always_comb begin
      // Advance every surviving candidate one step; fall back to a fresh search.
      hunt_next = {cand_q[SEQ_LEN-2:0], cand_q[SEQ_LEN-1]} & match_mask;
      if (hunt_next == '0) hunt_next = restart_mask;

      state_d    = state_q;
      cand_d     = cand_q;
      index_d    = index_q;
      miss_d     = miss_q;
      mismatch_d = 1'b0;
      err_d      = err_q;

      if (bus.in_valid) begin
         unique case (state_q)
            StHunt: begin
               if (is_one_hot(hunt_next)) begin
                  state_d = StLocked;
                  index_d = one_hot_index(hunt_next);
                  miss_d  = 3'd0;
               end else begin
                  cand_d = hunt_next;
               end
            end
            StLocked: begin
               index_d = index_q + 3'd1;
               if (bus.in_data == exp_val) begin
                  miss_d = 3'd0;
               end else begin
                  mismatch_d = 1'b1;
                  miss_d     = miss_q + 3'd1;
                  if (err_q != '1) err_d = err_q + 1'b1;
                  if (32'(miss_d) == ERR_LIMIT) begin
                     state_d = StHunt;
                     cand_d  = restart_mask;
                     index_d = 3'd0;
                  end
               end
            end
            default: ;
         endcase
      end

      if (bus.clr_err) err_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StHunt;
         cand_q     <= '1;
         index_q    <= 3'd0;
         miss_q     <= 3'd0;
         mismatch_q <= 1'b0;
         err_q      <= '0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         index_q    <= index_d;
         miss_q     <= miss_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
      end
   end

   assign bus.locked    = (state_q == StLocked);
   assign bus.index     = index_q;
   assign bus.expected  = (state_q == StLocked) ? exp_val : 3'd0;
   assign bus.mismatch  = mismatch_q;
   assign bus.err_count = err_q;

endmodule

// File: doc/seq_tracker.md
# seq_tracker

Receive-side companion to the 8-step sequence counter (`Dem`). It observes the counter's 3-bit output stream and finds where that stream sits in the fixed cycle 2,3,5,2,0,3,4,6 (indices 0..7). Once locked, it predicts each next value and flags mismatches; loads and glitches in the counter appear as mismatches. It sits after the counter as a checker or monitor and feeds lock and error status to the rest of the lab design.

## Interface
- `ERR_LIMIT`, default 2: consecutive mismatches while locked that force loss of lock. Legal range 1..7.
- `CNT_W`, default 16: width of the error counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: `in_data` carries a sample this cycle.
- `in_data` in 3: observed counter value.
- `clr_err` in 1: synchronous clear of `err_count`.
- `locked` out 1: tracker knows the sequence position.
- `index` out 3: index of the last accepted sample; 0 when unlocked.
- `expected` out 3: `SEQ[index+1 mod 8]` when locked; 0 when unlocked.
- `mismatch` out 1: one-cycle pulse when a locked sample differs from `expected`.
- `err_count` out CNT_W: saturating count of mismatches.

## Operation
- Constant: `SEQ` = {2,3,5,2,0,3,4,6}, indexed 0..7.
- Match mask: `match(v)` is an 8-bit vector whose bit i = (`SEQ[i]` == v).
  - match(2) = idx {0,3}; match(3) = {1,5}; match(5) = {2}; match(0) = {4}; match(4) = {6}; match(6) = {7}; match(1) = match(7) = {}.
- State HUNT (reset state): holds candidate mask `cand`, reset value 8'hFF.
  - On each valid sample, compute `n` = rotl1(`cand`) & match(`in_data`). rotl1 moves candidate i to i+1 mod 8.
  - If `n` == 0, `n` = match(`in_data`). If that is also 0, `n` = 8'hFF.
  - If `n` is one-hot: go to LOCKED, set `index` to the set bit, clear `miss_run`. Otherwise set `cand` = `n`.
  - Mismatches are not counted in HUNT.
- State LOCKED, on each valid sample:
  - `index` always advances by 1 mod 8 (flywheel).
  - If `in_data` == `expected`: clear `miss_run`.
  - Otherwise: pulse `mismatch`, increment `err_count` (saturates at all-ones), increment `miss_run`.
  - If `miss_run` reaches `ERR_LIMIT`: go to HUNT, set `cand` = match(`in_data`) (8'hFF if empty), set `index` = 0, deassert `locked`.
- `in_valid` = 0: no state change; `mismatch` = 0.
- `clr_err` has priority over a same-cycle increment: `err_count` becomes 0.
- `miss_run` is a 3-bit internal counter.

## Timing
- All outputs are registered. `expected` is decoded from the registered `index`.
- Latency: one cycle. A sample accepted at edge k is reflected in `locked`, `index`, `mismatch` and `err_count` after edge k.
- Fastest lock:
  - One sample for values 5, 0, 4 or 6.
  - Two samples for the pairs 2→3, 3→5, 2→0 and 3→4.
- Loss of lock happens on the same edge as the `ERR_LIMIT`-th consecutive mismatch. `mismatch` pulses on that edge too.
- Values at reset: `locked` = 0, `index` = 0, `expected` = 0, `mismatch` = 0, `err_count` = 0, state HUNT, `cand` = FF, `miss_run` = 0.
- Reset asserted mid-lock clears everything immediately, with no clock needed.

## Structure
- Shared package/header `seq_pkg`: `SEQ_LEN` = 8, the `SEQ` constant, state encodings HUNT/LOCKED. The counter and its bench use the same package.
- One sub-module, `seq_match_rom`: combinational value→8-bit match mask. It is reused for both the HUNT update and the lock-loss restart.
- The top level holds the FSM, `cand`, `index`, `miss_run` and the saturating `err_count`.

## Test plan
- Reset, then valid samples 2,3,5,2,0,3,4,6,2 on consecutive cycles.
  - `locked` rises after the 3, with `index` = 1.
  - `index` then steps 2..7,0; `mismatch` never pulses; `err_count` = 0.
- From reset, feed 4 → `locked` = 1, `index` = 6, `expected` = 6 next cycle. Feed 1,7 from reset → stays HUNT, `err_count` = 0.
- Locked at `index` 2; feed 5 then 2 (a simulated load), with `ERR_LIMIT` = 2.
  - First sample: `mismatch` pulse, `err_count` = 1, `index` = 3, still locked.
  - Second sample: `err_count` = 2, `locked` = 0.
  - Then feed 3 → relock with `index` = 1.
- Locked, toggle `in_valid` low for 5 cycles mid-stream → outputs frozen, no `mismatch`; resuming with the correct next value gives no error.
- `CNT_W` = 2: force 5 mismatches (`ERR_LIMIT` = 7) → `err_count` saturates at 3. `clr_err` asserted on the same cycle as a mismatch → `err_count` = 0.
- Assert `rst` asynchronously between clock edges while locked → all outputs at reset values before the next edge.
